// File: rtl/board_cursor_pkg.sv
// Shared defaults and enumerations for the board cursor controller.
package board_pkg;

  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 3;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_SEL,
    CMD_NEXT,
    CMD_UP,
    CMD_DOWN,
    CMD_LEFT,
    CMD_RIGHT
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    SEARCH
  } cursor_state_e;

endpackage

// File: rtl/board_cursor_if.sv
// Button/board-state/cursor bundle between the board buttons, the game logic and the cursor controller.
interface board_cursor_if
  import board_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  logic             btn_next;
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_sel;
  logic             enable;
  logic [CELLS-1:0] occupied;
  logic [IW-1:0]    cursor;
  logic [RW-1:0]    cursor_row;
  logic [CW-1:0]    cursor_col;
  logic             busy;
  logic             place_valid;
  logic [IW-1:0]    place_idx;
  logic             sel_reject;
  logic             board_full;

  modport master (
    output btn_next, btn_up, btn_down, btn_left, btn_right, btn_sel, enable, occupied,
    input  cursor, cursor_row, cursor_col, busy, place_valid, place_idx, sel_reject, board_full
  );

  modport slave (
    input  btn_next, btn_up, btn_down, btn_left, btn_right, btn_sel, enable, occupied,
    output cursor, cursor_row, cursor_col, busy, place_valid, place_idx, sel_reject, board_full
  );

endinterface

// File: rtl/board_cursor_btn_edge.sv
// Two-flop synchroniser plus registered rising-edge detect: one pulse per button press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse
);
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/board_cursor.sv
// Cursor controller for a ROWS x COLS board: button decode, directional/next moves,
// optional free-cell search and placement strobes toward the game logic.
module board_cursor
  import board_pkg::*;
#(
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter bit SKIP_OCCUPIED = 1'b1
) (
  input logic           clk,
  input logic           rst,
  board_cursor_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } pos_t;

  // Linear +1 with row/col carried alongside, so no division is ever needed.
  function automatic pos_t inc_pos(input pos_t p);
    pos_t n;
    n = p;
    if (p.col == CW'(COLS - 1)) begin
      n.col = '0;
      if (p.row == RW'(ROWS - 1)) begin
        n.row = '0;
        n.idx = '0;
      end else begin
        n.row = p.row + RW'(1);
        n.idx = p.idx + IW'(1);
      end
    end else begin
      n.col = p.col + CW'(1);
      n.idx = p.idx + IW'(1);
    end
    return n;
  endfunction

  logic [5:0]    w_raw;
  logic [5:0]    w_pulse;
  cmd_e          w_cmd;
  cursor_state_e r_state, w_state_next;
  pos_t          r_pos, w_pos_next;
  pos_t          r_cand, w_cand_next;
  logic [IW-1:0] r_steps, w_steps_next;
  logic [IW-1:0] r_place_idx, w_place_idx_next;
  logic          r_sel_reject, w_sel_reject_next;

  assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_next, bus.btn_sel};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_btn
      btn_edge u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (w_raw[gi]),
        .o_pulse (w_pulse[gi])
      );
    end
  endgenerate

  always_comb begin
    w_cmd = CMD_NONE;
    if      (w_pulse[0]) w_cmd = CMD_SEL;
    else if (w_pulse[1]) w_cmd = CMD_NEXT;
    else if (w_pulse[2]) w_cmd = CMD_UP;
    else if (w_pulse[3]) w_cmd = CMD_DOWN;
    else if (w_pulse[4]) w_cmd = CMD_LEFT;
    else if (w_pulse[5]) w_cmd = CMD_RIGHT;
  end

  always_comb begin
    w_state_next      = r_state;
    w_pos_next        = r_pos;
    w_cand_next       = r_cand;
    w_steps_next      = r_steps;
    w_place_idx_next  = r_place_idx;
    w_sel_reject_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          case (w_cmd)
            CMD_SEL: begin
              if (bus.occupied[r_pos.idx]) begin
                w_sel_reject_next = 1'b1;
              end else begin
                w_place_idx_next = r_pos.idx;
                w_state_next     = PLACE;
              end
            end
            CMD_NEXT: begin
              if (SKIP_OCCUPIED) begin
                w_cand_next  = inc_pos(r_pos);
                w_steps_next = '0;
                w_state_next = SEARCH;
              end else begin
                w_pos_next = inc_pos(r_pos);
              end
            end
            CMD_UP: begin
              w_pos_next.row = (r_pos.row == '0) ? RW'(ROWS - 1) : r_pos.row - RW'(1);
              w_pos_next.idx = (r_pos.row == '0) ? r_pos.idx + IW'((ROWS - 1) * COLS)
                                                 : r_pos.idx - IW'(COLS);
            end
            CMD_DOWN: begin
              w_pos_next.row = (r_pos.row == RW'(ROWS - 1)) ? '0 : r_pos.row + RW'(1);
              w_pos_next.idx = (r_pos.row == RW'(ROWS - 1)) ? r_pos.idx - IW'((ROWS - 1) * COLS)
                                                            : r_pos.idx + IW'(COLS);
            end
            CMD_LEFT: begin
              w_pos_next.col = (r_pos.col == '0) ? CW'(COLS - 1) : r_pos.col - CW'(1);
              w_pos_next.idx = (r_pos.col == '0) ? r_pos.idx + IW'(COLS - 1) : r_pos.idx - IW'(1);
            end
            CMD_RIGHT: begin
              w_pos_next.col = (r_pos.col == CW'(COLS - 1)) ? '0 : r_pos.col + CW'(1);
              w_pos_next.idx = (r_pos.col == CW'(COLS - 1)) ? r_pos.idx - IW'(COLS - 1)
                                                            : r_pos.idx + IW'(1);
            end
            default: ;
          endcase
        end
      end
      PLACE: begin
        if (SKIP_OCCUPIED) begin
          w_cand_next  = inc_pos(r_pos);
          w_steps_next = '0;
          w_state_next = SEARCH;
        end else begin
          w_state_next = IDLE;
        end
      end
      SEARCH: begin
        // The original cell is the last candidate, so a full lap leaves the cursor put.
        if (!bus.occupied[r_cand.idx]) begin
          w_pos_next   = r_cand;
          w_state_next = IDLE;
        end else if (r_steps == IW'(CELLS - 1)) begin
          w_state_next = IDLE;
        end else begin
          w_cand_next  = inc_pos(r_cand);
          w_steps_next = r_steps + IW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pos        <= '0;
      r_cand       <= '0;
      r_steps      <= '0;
      r_place_idx  <= '0;
      r_sel_reject <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pos        <= w_pos_next;
      r_cand       <= w_cand_next;
      r_steps      <= w_steps_next;
      r_place_idx  <= w_place_idx_next;
      r_sel_reject <= w_sel_reject_next;
    end
  end

  assign bus.cursor      = r_pos.idx;
  assign bus.cursor_row  = r_pos.row;
  assign bus.cursor_col  = r_pos.col;
  assign bus.busy        = (r_state == SEARCH) || (SKIP_OCCUPIED && (r_state == PLACE));
  assign bus.place_valid = (r_state == PLACE);
  assign bus.place_idx   = r_place_idx;
  assign bus.sel_reject  = r_sel_reject;
  assign bus.board_full  = &bus.occupied;

endmodule

// File: tb/tb_board_cursor.sv
// Bench for board_cursor: 3x3 linear, 3x3 skipping and 4x5 skipping instances, checked
// against vector tables, directed corner sequences and a random stream with a reference model.
module tb_board_cursor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [5:0]  btn [3];
  logic [19:0] occ [3];
  int          cur;
  int          checks;
  int          errors;
  int          mc [3];

  int   o_cursor, o_row, o_col, o_pidx;
  logic o_busy, o_pv, o_rej, o_full;

  board_cursor_if #(.ROWS(3), .COLS(3)) if0 ();
  board_cursor_if #(.ROWS(3), .COLS(3)) if1 ();
  board_cursor_if #(.ROWS(4), .COLS(5)) if2 ();

  assign {if0.btn_right, if0.btn_left, if0.btn_down, if0.btn_up, if0.btn_next, if0.btn_sel} = btn[0];
  assign {if1.btn_right, if1.btn_left, if1.btn_down, if1.btn_up, if1.btn_next, if1.btn_sel} = btn[1];
  assign {if2.btn_right, if2.btn_left, if2.btn_down, if2.btn_up, if2.btn_next, if2.btn_sel} = btn[2];
  assign if0.enable   = enable;
  assign if1.enable   = enable;
  assign if2.enable   = enable;
  assign if0.occupied = occ[0][8:0];
  assign if1.occupied = occ[1][8:0];
  assign if2.occupied = occ[2];

  board_cursor #(.ROWS(3), .COLS(3), .SKIP_OCCUPIED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  board_cursor #(.ROWS(3), .COLS(3), .SKIP_OCCUPIED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  board_cursor #(.ROWS(4), .COLS(5), .SKIP_OCCUPIED(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_cursor = 0; o_row = 0; o_col = 0; o_pidx = 0;
    o_busy = 1'b0; o_pv = 1'b0; o_rej = 1'b0; o_full = 1'b0;
    case (cur)
      0: begin
        o_cursor = int'(if0.cursor); o_row = int'(if0.cursor_row); o_col = int'(if0.cursor_col);
        o_pidx = int'(if0.place_idx); o_busy = if0.busy; o_pv = if0.place_valid;
        o_rej = if0.sel_reject; o_full = if0.board_full;
      end
      1: begin
        o_cursor = int'(if1.cursor); o_row = int'(if1.cursor_row); o_col = int'(if1.cursor_col);
        o_pidx = int'(if1.place_idx); o_busy = if1.busy; o_pv = if1.place_valid;
        o_rej = if1.sel_reject; o_full = if1.board_full;
      end
      default: begin
        o_cursor = int'(if2.cursor); o_row = int'(if2.cursor_row); o_col = int'(if2.cursor_col);
        o_pidx = int'(if2.place_idx); o_busy = if2.busy; o_pv = if2.place_valid;
        o_rej = if2.sel_reject; o_full = if2.board_full;
      end
    endcase
  end

  function automatic int rows_of(input int d);
    return (d == 2) ? 4 : 3;
  endfunction

  function automatic int cols_of(input int d);
    return (d == 2) ? 5 : 3;
  endfunction

  function automatic bit skip_of(input int d);
    return d != 0;
  endfunction

  // First free cell after c walking forward with wrap; cyc = candidates examined.
  function automatic int model_search(input int n, input int c, input logic [19:0] o, output int cyc);
    cyc = n;
    for (int i = 1; i <= n; i++) begin
      if (!o[(c + i) % n]) begin
        cyc = i;
        return (c + i) % n;
      end
    end
    return c;
  endfunction

  function automatic int model_move(input int d, input int c, input int b);
    int r = c / cols_of(d);
    int k = c % cols_of(d);
    case (b)
      2: r = (r + rows_of(d) - 1) % rows_of(d);
      3: r = (r + 1) % rows_of(d);
      4: k = (k + cols_of(d) - 1) % cols_of(d);
      5: k = (k + 1) % cols_of(d);
      default: ;
    endcase
    return r * cols_of(d) + k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input int d);
    cur = d;
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, cur, act, exp);
    end
  endtask

  // Raw press first sampled at edge k; returns just after edge k+3 with the cursor seen after edge k+2.
  task automatic press(input logic [5:0] m, output int pre);
    repeat (4) tick();
    btn[cur] = m;
    repeat (3) tick();
    pre = o_cursor;
    tick();
    btn[cur] = '0;
    $display("txn dut%0d btn %b en %0d cursor %0d busy %0d pv %0d pidx %0d rej %0d",
             cur, m, enable, o_cursor, o_busy, o_pv, o_pidx, o_rej);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (o_busy && cyc < 200) begin
      tick();
      cyc++;
    end
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout dut%0d: busy still 1 after %0d cycles, required 0", cur, cyc);
    end
  endtask

  typedef struct {
    int btn;
    int exp;
  } vec_t;

  initial begin
    vec_t        tbl [12];
    int          pre, cyc, ecyc, n, b, c, nc;
    logic        en, exp_pv, exp_rej;
    logic [19:0] mask, om;

    checks = 0; errors = 0; cur = 0;
    rst = 1'b0; enable = 1'b1;
    for (int d = 0; d < 3; d++) begin
      btn[d] = '0; occ[d] = '0; mc[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      pick(d);
      check("rst_cursor", o_cursor, 0);
      check("rst_row", o_row, 0);
      check("rst_col", o_col, 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_pv", int'(o_pv), 0);
      check("rst_rej", int'(o_rej), 0);
      check("rst_pidx", o_pidx, 0);
    end
    rst = 1'b1;

    // 3x3 linear stepping and directional wraps
    for (int i = 0; i < 9; i++) tbl[i] = '{1, (i + 1) % 9};
    tbl[9]  = '{4, 2};
    tbl[10] = '{2, 8};
    tbl[11] = '{3, 2};
    pick(0);
    c = 0;
    for (int i = 0; i < 12; i++) begin
      press(6'(1 << tbl[i].btn), pre);
      check("tbl_latency", pre, c);
      check("tbl_cursor", o_cursor, tbl[i].exp);
      check("tbl_row", o_row, tbl[i].exp / 3);
      check("tbl_col", o_col, tbl[i].exp % 3);
      c = tbl[i].exp;
    end

    repeat (4) tick();
    btn[0] = 6'b000010;
    repeat (20) tick();
    btn[0] = '0;
    repeat (4) tick();
    check("hold_next", o_cursor, 3);

    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      press(6'(1 << k), pre);
      check("dis_pv", int'(o_pv), 0);
      check("dis_rej", int'(o_rej), 0);
      repeat (2) tick();
      check("dis_cursor", o_cursor, 3);
    end
    enable = 1'b1;

    // 3x3 skipping: search past occupied cells, place, full board, reject
    pick(1);
    occ[1] = 20'b000001110;
    press(6'b000010, pre);
    wait_idle(cyc);
    check("skip_busy_cycles", cyc, 4);
    check("skip_cursor", o_cursor, 4);
    check("skip_row", o_row, 1);
    check("skip_col", o_col, 1);
    check("skip_full", int'(o_full), 0);
    press(6'b000001, pre);
    check("place_pv", int'(o_pv), 1);
    check("place_idx", o_pidx, 4);
    check("place_rej", int'(o_rej), 0);
    check("place_busy", int'(o_busy), 1);
    occ[1][4] = 1'b1;
    tick();
    check("place_pv_once", int'(o_pv), 0);
    wait_idle(cyc);
    check("place_advance", o_cursor, 5);
    occ[1] = 20'h001FF;
    #1;
    check("full_flag", int'(o_full), 1);
    press(6'b000010, pre);
    wait_idle(cyc);
    check("full_busy_cycles", cyc, 9);
    check("full_cursor", o_cursor, 5);
    press(6'b000001, pre);
    check("reject_rej", int'(o_rej), 1);
    check("reject_pv", int'(o_pv), 0);
    tick();
    check("reject_once", int'(o_rej), 0);
    check("reject_cursor", o_cursor, 5);

    // 4x5: sel beats next, then reset in the middle of a search
    pick(2);
    press(6'b000011, pre);
    check("prio_pv", int'(o_pv), 1);
    check("prio_idx", o_pidx, 0);
    occ[2][0] = 1'b1;
    wait_idle(cyc);
    check("prio_busy_cycles", cyc, 2);
    check("prio_cursor", o_cursor, 1);
    press(6'b000001, pre);
    check("place2_idx", o_pidx, 1);
    occ[2][1] = 1'b1;
    wait_idle(cyc);
    check("place2_cursor", o_cursor, 2);
    occ[2] = 20'hFFFFF;
    press(6'b000010, pre);
    repeat (3) tick();
    check("mid_busy", int'(o_busy), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_cursor", o_cursor, 0);
    check("mid_rst_row", o_row, 0);
    check("mid_rst_col", o_col, 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_pv", int'(o_pv), 0);
    check("mid_rst_rej", int'(o_rej), 0);
    check("mid_rst_pidx", o_pidx, 0);
    repeat (2) tick();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mc[d] = 0; occ[d] = '0;
    end

    // random command stream against the reference model
    for (int d = 0; d < 3; d++) begin
      pick(d);
      n = rows_of(d) * cols_of(d);
      mask = 20'((64'd1 << n) - 64'd1);
      repeat (40) begin
        occ[d] = 20'($urandom) & mask;
        case ($urandom_range(0, 7))
          0: occ[d] = mask;
          1: occ[d] = '0;
          default: ;
        endcase
        en = ($urandom_range(0, 5) != 0);
        b = $urandom_range(0, 5);
        c = mc[d]; nc = c; exp_pv = 1'b0; exp_rej = 1'b0; ecyc = 0;
        if (en) begin
          if (b == 0) begin
            if (occ[d][c]) exp_rej = 1'b1;
            else begin
              exp_pv = 1'b1;
              om = occ[d];
              om[c] = 1'b1;
              if (skip_of(d)) begin
                nc = model_search(n, c, om, ecyc);
                ecyc++;
              end
            end
          end else if (b == 1) begin
            if (skip_of(d)) nc = model_search(n, c, occ[d], ecyc);
            else nc = (c + 1) % n;
          end else begin
            nc = model_move(d, c, b);
          end
        end
        enable = en;
        press(6'(1 << b), pre);
        check("rnd_latency", pre, c);
        check("rnd_pv", int'(o_pv), int'(exp_pv));
        check("rnd_rej", int'(o_rej), int'(exp_rej));
        if (exp_pv) begin
          check("rnd_pidx", o_pidx, c);
          occ[d][c] = 1'b1;
        end
        wait_idle(cyc);
        check("rnd_busy_cycles", cyc, ecyc);
        check("rnd_cursor", o_cursor, nc);
        check("rnd_row", o_row, nc / cols_of(d));
        check("rnd_col", o_col, nc % cols_of(d));
        check("rnd_full", int'(o_full), int'(occ[d] == mask));
        mc[d] = nc;
      end
      enable = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
